// File: rtl/conv_sched.sv
// Convolution window scheduler: counts incoming pixels and, for every pixel that completes
// a KxK window, sequences the CIM input controller, crossbar and output function unit.
module conv_sched #(
  parameter int img_width  = 12,
  parameter int kernel_dim = 5,
  parameter int out_dim    = img_width - kernel_dim + 1,
  localparam int cnt_w     = (img_width > 1) ? $clog2(img_width) : 1,
  localparam int idx_w     = (out_dim * out_dim > 1) ? $clog2(out_dim * out_dim) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pixel_we,
  output logic             o_ready,
  output logic             o_ctrl_start,
  input  logic             i_ctrl_busy,
  input  logic             i_cim_busy,
  output logic             o_func_start,
  input  logic             i_func_busy,
  output logic             o_busy,
  output logic [idx_w-1:0] o_out_idx,
  output logic             o_frame_done,
  output logic             o_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START_CTRL,
    WAIT_CTRL,
    WAIT_CIM,
    START_FUNC,
    WAIT_FUNC
  } state_t;

  localparam logic [cnt_w-1:0] last_pix = cnt_w'(img_width - 1);
  localparam logic [cnt_w-1:0] first_hit = cnt_w'(kernel_dim - 1);
  localparam logic [idx_w-1:0] last_win = idx_w'(out_dim * out_dim - 1);

  state_t             state_q, state_d;
  logic [cnt_w-1:0]   row_q, row_d;
  logic [cnt_w-1:0]   col_q, col_d;
  logic [idx_w-1:0]   out_idx_q, out_idx_d;
  logic               first_q, first_d;
  logic               frame_done_q, frame_done_d;
  logic               overrun_q, overrun_d;
  logic               accept;
  logic               hit;

  assign o_ready      = (state_q == IDLE);
  assign o_busy       = (state_q != IDLE);
  assign o_ctrl_start = (state_q == START_CTRL);
  assign o_func_start = (state_q == START_FUNC);
  assign o_out_idx    = out_idx_q;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

  assign accept = i_pixel_we && (state_q == IDLE);
  assign hit    = (row_q >= first_hit) && (col_q >= first_hit);

  // NOTE: every variable gets a default before any branch, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    out_idx_d    = out_idx_q;
    first_d      = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (i_pixel_we & ~o_ready);

    if (accept) begin
      if (col_q == last_pix) begin
        col_d = '0;
        row_d = (row_q == last_pix) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE:       if (accept && hit) state_d = START_CTRL;
      START_CTRL: begin
        state_d = WAIT_CTRL;
        first_d = 1'b1;
      end
      // first_q masks the stale busy level seen in the cycle right after a start pulse
      WAIT_CTRL:  if (!first_q && !i_ctrl_busy) state_d = WAIT_CIM;
      WAIT_CIM:   if (!i_cim_busy) state_d = START_FUNC;
      START_FUNC: begin
        state_d = WAIT_FUNC;
        first_d = 1'b1;
      end
      WAIT_FUNC: begin
        if (!first_q && !i_func_busy) begin
          state_d      = IDLE;
          out_idx_d    = (out_idx_q == last_win) ? '0 : out_idx_q + 1'b1;
          frame_done_d = (out_idx_q == last_win);
        end
      end
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      out_idx_q    <= '0;
      first_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_idx_q    <= out_idx_d;
      first_q      <= first_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: a pixel-coordinate model predicts window starts and
// frame ends; a monitor compares them against DUT pulses while a responder emulates busys.
module tb_conv_sched;

  localparam int W    = 12;
  localparam int K    = 5;
  localparam int OD   = W - K + 1;
  localparam int NWIN = OD * OD;

  typedef struct {
    int win;
    int cyc;
  } start_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_pixel_we = 1'b0;
  logic       i_ctrl_busy = 1'b0;
  logic       i_cim_busy = 1'b0;
  logic       i_func_busy = 1'b0;
  logic       o_ready, o_ctrl_start, o_func_start, o_busy, o_frame_done, o_overrun;
  logic [5:0] o_out_idx;

  conv_sched #(.img_width(W), .kernel_dim(K)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pixel_we   (i_pixel_we),
    .o_ready      (o_ready),
    .o_ctrl_start (o_ctrl_start),
    .i_ctrl_busy  (i_ctrl_busy),
    .i_cim_busy   (i_cim_busy),
    .o_func_start (o_func_start),
    .i_func_busy  (i_func_busy),
    .o_busy       (o_busy),
    .o_out_idx    (o_out_idx),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pixel index within the frame, expected window starts and frame ends.
  int     pix = 0;
  start_t exp_q[$];
  int     done_q[$];

  task automatic model_accept();
    int     r;
    int     c;
    start_t e;
    r = pix / W;
    c = pix % W;
    if (r >= K - 1 && c >= K - 1) begin
      e.win = (r - K + 1) * OD + (c - K + 1);
      e.cyc = cyc + 1;
      exp_q.push_back(e);
      if (e.win == NWIN - 1) done_q.push_back(e.win);
    end
    pix = (pix + 1) % (W * W);
  endtask

  // Busy responder: each unit stays busy for a programmable number of cycles.
  int   ctrl_lat = 0, cim_lat = 0, func_lat = 0;
  logic rand_lat = 1'b0;
  int   ctrl_cnt = 0, cim_cnt = 0, func_cnt = 0;

  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin
      ctrl_cnt = 0;
      cim_cnt  = 0;
      func_cnt = 0;
    end else begin
      if (ctrl_cnt > 0) begin
        ctrl_cnt--;
        if (ctrl_cnt == 0) cim_cnt = cim_lat;
      end else if (cim_cnt > 0) begin
        cim_cnt--;
      end
      if (func_cnt > 0) func_cnt--;
      if (o_ctrl_start) begin
        if (rand_lat) begin
          ctrl_lat = $urandom_range(3, 0);
          cim_lat  = $urandom_range(3, 0);
          func_lat = $urandom_range(3, 0);
        end
        ctrl_cnt = ctrl_lat + 1;
      end
      if (o_func_start) func_cnt = func_lat + 1;
    end
    i_ctrl_busy = (ctrl_cnt > 0);
    i_cim_busy  = (cim_cnt > 0);
    i_func_busy = (func_cnt > 0);
  end

  // Monitor: pops the scoreboard whenever the DUT pulses.
  int     n_ctrl = 0, n_func = 0, n_done = 0;
  int     cur_win = 0;
  logic   in_flight = 1'b0;
  logic   prev_busy = 1'b0, prev_cim = 1'b0, prev_func = 1'b0;
  start_t mon_e;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_busy = 1'b0;
      in_flight = 1'b0;
    end else begin
      check("ready_is_not_busy", o_ready, !o_busy);
      check("starts_exclusive", o_ctrl_start & o_func_start, 0);
      if (o_ctrl_start) begin
        n_ctrl++;
        check("ctrl_start_no_window_open", in_flight, 0);
        if (exp_q.size() == 0) begin
          check("ctrl_start_expected", o_ctrl_start, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("start_out_idx", o_out_idx, mon_e.win);
          check("start_latency_cycle", cyc, mon_e.cyc);
          cur_win = mon_e.win;
        end
        in_flight = 1'b1;
      end
      if (o_func_start) begin
        n_func++;
        check("func_start_in_window", in_flight, 1);
        check("cim_busy_low_before_func", prev_cim, 0);
      end
      if (prev_busy && !o_busy) begin
        check("func_busy_low_at_exit", prev_func, 0);
        check("out_idx_after_window", o_out_idx, (cur_win + 1) % NWIN);
        in_flight = 1'b0;
      end
      if (o_frame_done) begin
        n_done++;
        if (done_q.size() == 0) begin
          check("frame_done_expected", o_frame_done, 0);
        end else begin
          void'(done_q.pop_front());
          check("frame_done_out_idx", o_out_idx, 0);
        end
      end
      prev_busy = o_busy;
      prev_cim  = i_cim_busy;
      prev_func = i_func_busy;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_pixels(input int n, input int gap_max, input logic want_ready);
    int budget;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(gap_max, 0)) step();
      if (want_ready) check("ready_before_non_hit", o_ready, 1);
      budget = 0;
      while (!o_ready && budget < 300) begin
        step();
        budget++;
      end
      if (!o_ready) begin
        check("ready_within_budget", o_ready, 1);
        return;
      end
      i_pixel_we = 1'b1;
      model_accept();
      step();
      i_pixel_we = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (!o_ready && budget < 300) begin
      step();
      budget++;
    end
    if (!o_ready) check("idle_within_budget", o_ready, 1);
    step();
  endtask

  int ctrl_before;
  int budget_m;

  initial begin
    // Reset values
    #2;
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_out_idx", o_out_idx, 0);
    check("rst_ctrl_start", o_ctrl_start, 0);
    check("rst_func_start", o_func_start, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_overrun", o_overrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    step();

    // First 52 writes produce no window; the 53rd at (4,4) starts window 0
    ctrl_lat = 3; cim_lat = 5; func_lat = 4;
    write_pixels(52, 0, 1'b1);
    check("no_start_before_53rd", n_ctrl, 0);
    write_pixels(1, 0, 1'b0);
    wait_idle();
    check("one_ctrl_start", n_ctrl, 1);
    check("one_func_start", n_func, 1);
    check("out_idx_after_first", o_out_idx, 1);

    // Remainder of the frame with random gaps and latencies
    rand_lat = 1'b1;
    write_pixels(W * W - 53, 2, 1'b0);
    wait_idle();
    check("frame_ctrl_starts", n_ctrl, NWIN);
    check("frame_func_starts", n_func, NWIN);
    check("frame_done_count", n_done, 1);
    check("frame_out_idx_wrap", o_out_idx, 0);
    check("frame_starts_drained", exp_q.size(), 0);

    // Write attempt while busy in WAIT_CIM sets the sticky overrun
    rand_lat = 1'b0;
    ctrl_lat = 3; cim_lat = 5; func_lat = 4;
    write_pixels(52, 0, 1'b1);
    check("overrun_clear_before", o_overrun, 0);
    write_pixels(1, 0, 1'b0);
    repeat (6) step();
    check("busy_at_overrun_write", o_ready, 0);
    i_pixel_we = 1'b1;
    step();
    i_pixel_we = 1'b0;
    check("overrun_set", o_overrun, 1);
    wait_idle();
    check("overrun_sticky", o_overrun, 1);
    write_pixels(1, 0, 1'b0);
    wait_idle();
    check("counters_ignored_overrun", o_out_idx, 2);

    // Reset mid WAIT_FUNC aborts the window
    func_lat = 8;
    write_pixels(1, 0, 1'b0);
    budget_m = 0;
    while (!o_func_start && budget_m < 100) begin
      step();
      budget_m++;
    end
    check("func_start_seen", o_func_start, 1);
    repeat (3) step();
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("async_rst_busy", o_busy, 0);
    check("async_rst_ready", o_ready, 1);
    check("async_rst_out_idx", o_out_idx, 0);
    check("async_rst_overrun", o_overrun, 0);
    exp_q.delete();
    done_q.delete();
    pix = 0;
    ctrl_before = n_ctrl;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    step();
    check("no_start_during_reset", n_ctrl, ctrl_before);
    rand_lat = 1'b1;
    write_pixels(52, 0, 1'b1);
    check("restart_no_early_start", n_ctrl, ctrl_before);
    write_pixels(1, 0, 1'b0);
    wait_idle();
    check("restart_first_start", n_ctrl, ctrl_before + 1);
    check("restart_out_idx", o_out_idx, 1);
    check("final_starts_drained", exp_q.size(), 0);
    check("final_done_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Parameters
REQ-001 The block SHALL have parameter img_width, default 12, meaning input image width and height in pixels (square image).
REQ-002 The block SHALL have parameter kernel_dim, default 5, meaning kernel dimension N (NxN window), with 1 <= kernel_dim <= img_width.
REQ-003 The block SHALL have parameter out_dim, default img_width-kernel_dim+1, meaning output pixels per row and column (stride 1, no padding).

Interface
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-006 i_pixel_we  input  1  previous layer writes one pixel (all channels) into the input buffers this cycle.
REQ-007 o_ready  output  1  high when a pixel write is accepted; equals (state == IDLE).
REQ-008 o_ctrl_start  output  1  one-cycle pulse starting the CIM input controller for the current window.
REQ-009 i_ctrl_busy  input  1  CIM input controller busy.
REQ-010 i_cim_busy  input  1  crossbar compute busy.
REQ-011 o_func_start  output  1  one-cycle pulse starting the output function unit.
REQ-012 i_func_busy  input  1  output function unit busy.
REQ-013 o_busy  output  1  high whenever state != IDLE.
REQ-014 o_out_idx  output  $clog2(out_dim**2)  index of the window being processed, row-major.
REQ-015 o_frame_done  output  1  one-cycle pulse after the last window of a frame completes.
REQ-016 o_overrun  output  1  sticky flag: pixel write attempted while o_ready low.

Function
REQ-017 Pixel counters row, col (each $clog2(img_width) bits) SHALL advance on every accepted write (i_pixel_we & o_ready): col+1; at col == img_width-1, col wraps to 0 and row+1; at row == img_width-1 and col == img_width-1, both wrap to 0.
REQ-018 A write to pixel (row,col) SHALL be a window hit iff row >= kernel_dim-1 and col >= kernel_dim-1.
REQ-019 States SHALL be IDLE, START_CTRL, WAIT_CTRL, WAIT_CIM, START_FUNC, WAIT_FUNC.
REQ-020 IDLE: accepted write that is a window hit -> START_CTRL the next cycle; non-hit write stays IDLE, with o_ready held high.
REQ-021 START_CTRL: o_ctrl_start = 1 for exactly this cycle; unconditional -> WAIT_CTRL.
REQ-022 WAIT_CTRL: busy input ignored in the first cycle; thereafter -> WAIT_CIM in the first cycle with i_ctrl_busy == 0.
REQ-023 WAIT_CIM: -> START_FUNC in the first cycle with i_cim_busy == 0 (may be the entry cycle).
REQ-024 START_FUNC: o_func_start = 1 for exactly this cycle; unconditional -> WAIT_FUNC.
REQ-025 WAIT_FUNC: busy input ignored in the first cycle; thereafter, in the first cycle with i_func_busy == 0 -> IDLE, and o_out_idx increments (wrapping to 0 after out_dim**2-1).
REQ-026 When the WAIT_FUNC exit completes window out_dim**2-1, o_frame_done SHALL pulse in the following cycle, the first IDLE cycle.
REQ-027 Write-to-start latency SHALL be 1 cycle: a hit accepted in cycle t gives o_ctrl_start high in cycle t+1.
REQ-028 i_pixel_we while o_ready == 0 SHALL be ignored (no counter change) and SHALL set o_overrun, which clears only on reset.
REQ-029 Busy inputs SHALL have no effect in IDLE, START_CTRL or START_FUNC.
REQ-030 o_ctrl_start and o_func_start SHALL never be high in the same cycle.

Reset
REQ-031 While rst == 0: state = IDLE; row, col, o_out_idx = 0; o_ctrl_start, o_func_start, o_frame_done, o_overrun, o_busy = 0; o_ready = 1.
REQ-032 Reset asserted mid-window SHALL abort the window immediately, with no further start pulses, and the next frame SHALL restart at pixel (0,0).

Verification (img_width=12, kernel_dim=5)
REQ-033 Reset, then 52 writes with busys low -> no o_ctrl_start, o_ready always 1; the 53rd write (row 4, col 4) -> o_ctrl_start the next cycle, o_out_idx = 0.
REQ-034 Hit with i_ctrl_busy held 3 cycles, i_cim_busy 5 cycles, i_func_busy 4 cycles -> exactly one o_ctrl_start and one o_func_start, each preceding stage's busy observed low first, and o_out_idx 0 -> 1 on return to IDLE.
REQ-035 Full 144-pixel frame with single-cycle busys -> 64 o_ctrl_start and 64 o_func_start pulses, one o_frame_done after the 64th window, o_out_idx = 0, row = col = 0.
REQ-036 i_pixel_we asserted during WAIT_CIM -> pixel counters unchanged, o_overrun = 1 until reset.
REQ-037 rst pulsed low during WAIT_FUNC -> o_busy = 0 and o_ready = 1 asynchronously, o_out_idx = 0, no o_frame_done; the next frame's first start follows its 53rd write.
